// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: WIDTH-bit operands, DIGIT bits per clock through a ripple chain.
// Optional signed-overflow output enabled by defining DSA_OVF_EN.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef DSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
`ifdef DSA_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [DIGIT-1:0]       sum_dig;
    logic [DIGIT:0]         c;
    logic [WIDTH+DIGIT-1:0] part_wide;
    logic [WIDTH-1:0]       part_next;

    // Team full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    always_comb begin
        c[0] = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            {c[i+1], sum_dig[i]} = full_add(a_q[i], b_q[i], c[i]);
        end
        // Sum digits enter at the MSB end so the first (least significant) digit ends up lowest.
        part_wide = {sum_dig, part_q};
        part_next = part_wide[WIDTH+DIGIT-1:DIGIT];
    end

    always_comb begin
        // NOTE: every _d gets a default hold value first, so no path through this block infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef DSA_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = c[DIGIT];
                part_d  = part_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = part_next;
                    cout_d  = c[DIGIT];
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef DSA_OVF_EN
                    ovf_d   = c[DIGIT-1] ^ c[DIGIT];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DSA_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef DSA_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
`ifdef DSA_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: vector table plus scoreboard, hold-start, back-to-back and mid-op reset.
module tb_digit_serial_adder;
    localparam int WIDTH = 16;
    parameter  int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    logic        clk, rst_n, start, sub, cin;
    logic [15:0] a, b, s;
    logic        busy, done, cout;
`ifdef DSA_OVF_EN
    logic        ovf;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t sb[$];
    vec_t tbl[9];

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .s(s), .cout(cout)
`ifdef DSA_OVF_EN
        , .ovf(ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic at word level: two's-complement add/sub with signed-overflow rule.
    function automatic vec_t model(input logic op_sub, input logic [15:0] x, input logic [15:0] y,
                                   input logic ci);
        vec_t        v;
        logic [15:0] ye;
        logic [16:0] r;
        ye   = op_sub ? ~y : y;
        r    = {1'b0, x} + {1'b0, ye} + {16'd0, (op_sub ? 1'b1 : ci)};
        v.sub = op_sub; v.a = x; v.b = y; v.cin = ci;
        v.es = r[15:0];
        v.ec = r[16];
        v.eo = (x[15] == ye[15]) && (r[15] != x[15]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, want no pending operation");
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("s", {16'd0, s}, {16'd0, e.es});
                check("cout", {31'd0, cout}, {31'd0, e.ec});
`ifdef DSA_OVF_EN
                check("ovf", {31'd0, ovf}, {31'd0, e.eo});
`endif
            end
        end
    end

    task automatic run_op(input vec_t v, input bit hold);
        int n;
        int nbusy;
        sub = v.sub; a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        nbusy = 1;
        if (!hold) start = 1'b0;
        n = 0;
        while (!done && n < NDIG + 4) begin
            if (hold) begin
                a = 16'($urandom); b = 16'($urandom);
                sub = 1'($urandom); cin = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
            if (busy) nbusy++;
        end
        check("latency", n, NDIG);
        check("busy_cycles", nbusy, NDIG);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dcnt;
        tbl[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_s", {16'd0, s}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_op(tbl[i], 1'b0);

        // start held through RUN with scrambled inputs, then a new op accepted in the done cycle.
        run_op('{1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0}, 1'b1);
        run_op('{1'b1, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0}, 1'b0);

        // Abandon an operation with reset after the second digit.
        sub = 1'b0; a = 16'hABCD; b = 16'h1357; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat ((NDIG > 2) ? 2 : NDIG - 1) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_s", {16'd0, s}, 32'd0);
        check("midrst_cout", {31'd0, cout}, 32'd0);
`ifdef DSA_OVF_EN
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        dcnt = 0;
        repeat (NDIG + 3) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("no_done_after_reset", dcnt, 0);
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        run_op(tbl[0], 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(model(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom)), 1'b0);
        end

        @(posedge clk); #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
